// File: rtl/adc_pulse_emulator_pkg.sv
// Shared definitions for the synthetic ADC pulse source: FSM encoding,
// latched run configuration and the saturating sample arithmetic.
package adc_pulse_emulator_pkg;

  localparam int ADC_DW = 16;
  localparam int CNT_W  = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [CNT_W-1:0]  period;
    logic [15:0]       burst_count;
    logic [15:0]       width;
    logic [CNT_W-1:0]  delay_ab;
    logic [CNT_W-1:0]  delay_bc;
    logic [ADC_DW-1:0] baseline;
    logic [ADC_DW-1:0] amp_a;
    logic [ADC_DW-1:0] amp_b;
    logic [ADC_DW-1:0] amp_c;
  } cfg_t;

  // base +/- amp at 17 bits, clamped to the signed 16-bit range on overflow
  function automatic logic [15:0] sat16(input logic [15:0] base, input logic [15:0] amp,
                                        input logic sub);
    logic [16:0] sum;
    logic [15:0] res;
    if (sub) begin
      sum = {base[15], base} - {amp[15], amp};
    end else begin
      sum = {base[15], base} + {amp[15], amp};
    end
    if (sum[16] != sum[15]) begin
      res = sum[16] ? 16'h8000 : 16'h7fff;
    end else begin
      res = sum[15:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_pulse_emulator_if.sv
// Configuration and sample-stream bundle of the pulse emulator; the
// emulator is the slave, whoever drives configuration is the master.
interface adc_pulse_emulator_if;
  import adc_pulse_emulator_pkg::*;

  logic                gen_enable;
  logic [CNT_W-1:0]    holdoff;
  logic [CNT_W-1:0]    period;
  logic [15:0]         burst_count;
  logic [15:0]         width;
  logic [CNT_W-1:0]    delay_ab;
  logic [CNT_W-1:0]    delay_bc;
  logic [ADC_DW-1:0]   baseline;
  logic [ADC_DW-1:0]   amp_a;
  logic [ADC_DW-1:0]   amp_b;
  logic [ADC_DW-1:0]   amp_c;
  logic [2*ADC_DW-1:0] adc_data_a;
  logic [2*ADC_DW-1:0] adc_data_b;
  logic [2*ADC_DW-1:0] adc_data_c;
  logic [2*ADC_DW-1:0] adc_data_d;
  logic                adc_enable;
  logic                adc_valid;
  logic                frame_start;
  logic [15:0]         frame_count;
  logic                busy;

  modport master (
    output gen_enable, holdoff, period, burst_count, width, delay_ab, delay_bc,
           baseline, amp_a, amp_b, amp_c,
    input  adc_data_a, adc_data_b, adc_data_c, adc_data_d, adc_enable, adc_valid,
           frame_start, frame_count, busy
  );

  modport slave (
    input  gen_enable, holdoff, period, burst_count, width, delay_ab, delay_bc,
           baseline, amp_a, amp_b, amp_c,
    output adc_data_a, adc_data_b, adc_data_c, adc_data_d, adc_enable, adc_valid,
           frame_start, frame_count, busy
  );

endinterface

// File: rtl/adc_pulse_emulator_pulse_window_gen.sv
// Half-open pulse window test for the two samples (2t, 2t+1) of one word,
// clipped to the frame length of 2*period samples.
module adc_pulse_emulator_pulse_window_gen #(
  parameter int CNT_WIDTH = 32
) (
  input  logic [CNT_WIDTH-1:0] t,
  input  logic [CNT_WIDTH:0]   start,
  input  logic [15:0]          width,
  input  logic [CNT_WIDTH-1:0] period,
  output logic [1:0]           mask
);

  logic [CNT_WIDTH+1:0] s_lo_s;
  logic [CNT_WIDTH+1:0] s_hi_s;
  logic [CNT_WIDTH+1:0] start_s;
  logic [CNT_WIDTH+1:0] end_s;
  logic [CNT_WIDTH+1:0] lim_s;

  // One spare bit above the widest sum keeps start+width from wrapping
  assign s_lo_s  = {1'b0, t, 1'b0};
  assign s_hi_s  = {1'b0, t, 1'b1};
  assign start_s = {1'b0, start};
  assign end_s   = start_s + {{(CNT_WIDTH-14){1'b0}}, width};
  assign lim_s   = {1'b0, period, 1'b0};

  assign mask[0] = (s_lo_s >= start_s) && (s_lo_s < end_s) && (s_lo_s < lim_s);
  assign mask[1] = (s_hi_s >= start_s) && (s_hi_s < end_s) && (s_hi_s < lim_s);

endmodule

// File: rtl/adc_pulse_emulator.sv
// Synthetic 4-channel ADC word source: A rising, B falling, C rising pulses per
// frame over a baseline, two samples per word, one registered output stage.
module adc_pulse_emulator
  import adc_pulse_emulator_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = ADC_DW,
  parameter int CNT_WIDTH      = CNT_W
) (
  input logic                clk,
  input logic                rstn,
  adc_pulse_emulator_if.slave pe
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                  state_r, state_next_s;
  cfg_t                        cfg_r;
  logic [CNT_WIDTH-1:0]        hold_r, t_r;
  logic [15:0]                 frame_count_r;
  logic                        wrap_s, last_s;
  logic [CNT_WIDTH:0]          start_b_s, start_c_s;
  logic [1:0]                  mask_a_s, mask_b_s, mask_c_s;
  logic [ADC_DATA_WIDTH-1:0]   pa_s, pb_s, pc_s, base_s;
  logic [2*ADC_DATA_WIDTH-1:0] data_a_r, data_b_r, data_c_r, data_d_r;
  logic                        valid_r, enable_r, fs_r, busy_r;

  assign wrap_s    = (t_r == cfg_r.period - CNT_ONE);
  assign last_s    = wrap_s && (cfg_r.burst_count != 16'd0) &&
                     ((frame_count_r + 16'd1) == cfg_r.burst_count);
  assign start_b_s = {1'b0, cfg_r.delay_ab};
  assign start_c_s = {1'b0, cfg_r.delay_ab} + {1'b0, cfg_r.delay_bc};
  assign base_s    = cfg_r.baseline;
  assign pa_s      = sat16(cfg_r.baseline, cfg_r.amp_a, 1'b0);
  assign pb_s      = sat16(cfg_r.baseline, cfg_r.amp_b, 1'b1);
  assign pc_s      = sat16(cfg_r.baseline, cfg_r.amp_c, 1'b0);

  adc_pulse_emulator_pulse_window_gen #(.CNT_WIDTH(CNT_WIDTH)) u_win_a (
    .t(t_r), .start({(CNT_WIDTH+1){1'b0}}), .width(cfg_r.width), .period(cfg_r.period),
    .mask(mask_a_s));
  adc_pulse_emulator_pulse_window_gen #(.CNT_WIDTH(CNT_WIDTH)) u_win_b (
    .t(t_r), .start(start_b_s), .width(cfg_r.width), .period(cfg_r.period), .mask(mask_b_s));
  adc_pulse_emulator_pulse_window_gen #(.CNT_WIDTH(CNT_WIDTH)) u_win_c (
    .t(t_r), .start(start_c_s), .width(cfg_r.width), .period(cfg_r.period), .mask(mask_c_s));

  // Next-state logic; dropping gen_enable always returns to IDLE
  always_comb begin
    state_next_s = state_r;
    if (!pe.gen_enable) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_next_s = ST_ARM;
        ST_ARM:  state_next_s = (hold_r == '0) ? ST_RUN : ST_ARM;
        ST_RUN:  state_next_s = last_s ? ST_DONE : ST_RUN;
        ST_DONE: state_next_s = ST_DONE;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // State, configuration latch, holdoff/timeline and frame counters
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r       <= ST_IDLE;
      cfg_r         <= '0;
      hold_r        <= '0;
      t_r           <= '0;
      frame_count_r <= 16'd0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        ST_IDLE: begin
          if (pe.gen_enable) begin
            cfg_r.period      <= (pe.period == '0) ? CNT_ONE : pe.period;
            cfg_r.burst_count <= pe.burst_count;
            cfg_r.width       <= pe.width;
            cfg_r.delay_ab    <= pe.delay_ab;
            cfg_r.delay_bc    <= pe.delay_bc;
            cfg_r.baseline    <= pe.baseline;
            cfg_r.amp_a       <= pe.amp_a;
            cfg_r.amp_b       <= pe.amp_b;
            cfg_r.amp_c       <= pe.amp_c;
            hold_r            <= pe.holdoff;
          end
        end
        ST_ARM: begin
          t_r <= '0;
          if (hold_r != '0) begin
            hold_r <= hold_r - CNT_ONE;
          end
        end
        ST_RUN: begin
          if (wrap_s) begin
            t_r           <= '0;
            frame_count_r <= frame_count_r + 16'd1;
          end else begin
            t_r <= t_r + CNT_ONE;
          end
        end
        default: begin
        end
      endcase
      if (state_next_s == ST_IDLE) begin
        frame_count_r <= 16'd0;
      end
    end
  end

  // Output stage: the word for timeline t is registered from the counter value t
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_a_r <= '0;
      data_b_r <= '0;
      data_c_r <= '0;
      data_d_r <= '0;
      valid_r  <= 1'b0;
      enable_r <= 1'b0;
      fs_r     <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      enable_r <= pe.gen_enable && (state_r != ST_IDLE);
      busy_r   <= pe.gen_enable && ((state_r == ST_ARM) || (state_r == ST_RUN));
      valid_r  <= pe.gen_enable && (state_r == ST_RUN);
      fs_r     <= pe.gen_enable && (state_r == ST_RUN) && (t_r == '0);
      if (!pe.gen_enable || (state_r == ST_IDLE)) begin
        data_a_r <= {pe.baseline, pe.baseline};
        data_b_r <= {pe.baseline, pe.baseline};
        data_c_r <= {pe.baseline, pe.baseline};
        data_d_r <= {pe.baseline, pe.baseline};
      end else if (state_r == ST_RUN) begin
        data_a_r <= {mask_a_s[1] ? pa_s : base_s, mask_a_s[0] ? pa_s : base_s};
        data_b_r <= {mask_b_s[1] ? pb_s : base_s, mask_b_s[0] ? pb_s : base_s};
        data_c_r <= {mask_c_s[1] ? pc_s : base_s, mask_c_s[0] ? pc_s : base_s};
        data_d_r <= {base_s, base_s};
      end else begin
        data_a_r <= {base_s, base_s};
        data_b_r <= {base_s, base_s};
        data_c_r <= {base_s, base_s};
        data_d_r <= {base_s, base_s};
      end
    end
  end

  assign pe.adc_data_a  = data_a_r;
  assign pe.adc_data_b  = data_b_r;
  assign pe.adc_data_c  = data_c_r;
  assign pe.adc_data_d  = data_d_r;
  assign pe.adc_valid   = valid_r;
  assign pe.adc_enable  = enable_r;
  assign pe.frame_start = fs_r;
  assign pe.frame_count = frame_count_r;
  assign pe.busy        = busy_r;

endmodule

// File: tb/tb_adc_pulse_emulator.sv
// Self-checking bench for adc_pulse_emulator: directed scenarios plus random
// configurations, each word compared against a sample-level reference model.
module tb_adc_pulse_emulator;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  longint c_hold, c_peff, c_width, c_ab, c_bc;
  int     c_burst, c_base;
  int     c_amp[3];
  logic [31:0] cap_a[$], cap_b[$], cap_c[$];

  always #4 clk = ~clk;

  adc_pulse_emulator_if pe();

  adc_pulse_emulator dut (.clk(clk), .rstn(rstn), .pe(pe));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference sample value for channel ch (0=A,1=B,2=C,3=D) at sample index s
  function automatic logic [15:0] ref_sample(input int ch, input longint s);
    longint st;
    longint v;
    st = (ch == 0) ? 0 : (ch == 1) ? c_ab : c_ab + c_bc;
    v = c_base;
    if (ch < 3 && s >= st && s < st + c_width && s < 2 * c_peff)
      v = (ch == 1) ? c_base - c_amp[1] : c_base + c_amp[ch];
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  function automatic logic [31:0] ref_word(input int ch, input longint t);
    return {ref_sample(ch, 2 * t + 1), ref_sample(ch, 2 * t)};
  endfunction

  function automatic logic [31:0] base_word();
    logic [31:0] b;
    b = {c_base[15:0], c_base[15:0]};
    return b;
  endfunction

  task automatic program_cfg(input int hold, input int per, input int burst, input int wid,
                             input int ab, input int bc, input int base,
                             input int aa, input int amb, input int ac);
    pe.holdoff = hold; pe.period = per; pe.burst_count = burst[15:0]; pe.width = wid[15:0];
    pe.delay_ab = ab; pe.delay_bc = bc; pe.baseline = base[15:0];
    pe.amp_a = aa[15:0]; pe.amp_b = amb[15:0]; pe.amp_c = ac[15:0];
    c_hold = hold; c_peff = (per == 0) ? 1 : per; c_burst = burst & 16'hffff;
    c_width = wid & 16'hffff; c_ab = ab; c_bc = bc;
    c_base = $signed(base[15:0]);
    c_amp[0] = $signed(aa[15:0]); c_amp[1] = $signed(amb[15:0]); c_amp[2] = $signed(ac[15:0]);
  endtask

  // Enable from IDLE, check ARM, the word stream and the end of the run
  task automatic run_cfg(input int n_words);
    int total;
    longint t;
    cap_a.delete(); cap_b.delete(); cap_c.delete();
    pe.gen_enable = 1'b1;
    @(posedge clk); #1;
    chk("e0_enable", pe.adc_enable, 32'd0);
    chk("e0_valid", pe.adc_valid, 32'd0);
    // Live inputs change after the latch point; the run must ignore them
    pe.amp_a = 16'h1234; pe.width = 16'd3; pe.delay_ab = 32'd1; pe.period = 32'd5;
    pe.burst_count = 16'd7; pe.holdoff = 32'd9;
    for (int j = 1; j <= c_hold + 1; j++) begin
      @(posedge clk); #1;
      chk($sformatf("arm%0d_valid", j), pe.adc_valid, 32'd0);
      chk($sformatf("arm%0d_busy", j), pe.busy, 32'd1);
      chk($sformatf("arm%0d_enable", j), pe.adc_enable, 32'd1);
    end
    total = (c_burst != 0) ? c_burst * int'(c_peff) : n_words;
    for (int k = 0; k < total; k++) begin
      @(posedge clk); #1;
      t = k % c_peff;
      cap_a.push_back(pe.adc_data_a); cap_b.push_back(pe.adc_data_b);
      cap_c.push_back(pe.adc_data_c);
      chk($sformatf("w%0d_valid", k), pe.adc_valid, 32'd1);
      chk($sformatf("w%0d_fs", k), pe.frame_start, (t == 0) ? 32'd1 : 32'd0);
      chk($sformatf("w%0d_a", k), pe.adc_data_a, ref_word(0, t));
      chk($sformatf("w%0d_b", k), pe.adc_data_b, ref_word(1, t));
      chk($sformatf("w%0d_c", k), pe.adc_data_c, ref_word(2, t));
      chk($sformatf("w%0d_d", k), pe.adc_data_d, ref_word(3, t));
      chk($sformatf("w%0d_fc", k), pe.frame_count, 32'((k + 1) / int'(c_peff)));
    end
    if (c_burst != 0) begin
      @(posedge clk); #1;
      chk("done_valid", pe.adc_valid, 32'd0);
      chk("done_busy", pe.busy, 32'd0);
      chk("done_enable", pe.adc_enable, 32'd1);
      chk("done_fc", pe.frame_count, 32'(c_burst));
      chk("done_data", pe.adc_data_a, base_word());
    end
    pe.gen_enable = 1'b0;
    @(posedge clk); #1;
    chk("off_valid", pe.adc_valid, 32'd0);
    chk("off_enable", pe.adc_enable, 32'd0);
    chk("off_fc", pe.frame_count, 32'd0);
    chk("off_data", pe.adc_data_d, base_word());
  endtask

  initial begin
    pe.gen_enable = 1'b0;
    program_cfg(0, 20, 1, 4, 10, 6, 0, 1000, 1000, 1000);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", pe.adc_data_a, 32'd0);
    chk("rst_valid", pe.adc_valid, 32'd0);
    chk("rst_fc", pe.frame_count, 32'd0);
    chk("rst_busy", pe.busy, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 1: basic A/B/C placement, single frame
    run_cfg(0);
    chk("t1_a0", cap_a[0], 32'h03E803E8);
    chk("t1_a1", cap_a[1], 32'h03E803E8);
    chk("t1_a2", cap_a[2], 32'h00000000);
    chk("t1_b5", cap_b[5], 32'hFC18FC18);
    chk("t1_b6", cap_b[6], 32'hFC18FC18);
    chk("t1_c8", cap_c[8], 32'h03E803E8);
    chk("t1_c9", cap_c[9], 32'h03E803E8);

    // 2: odd delay splits the B edge across the word halves
    program_cfg(0, 20, 1, 2, 11, 6, 0, 1000, 1000, 1000);
    run_cfg(0);
    chk("t2_b5", cap_b[5], 32'hFC180000);
    chk("t2_b6", cap_b[6], 32'h0000FC18);

    // 3: saturation both ways
    program_cfg(1, 4, 1, 2, 0, 0, 32000, 2000, 0, 0);
    run_cfg(0);
    chk("t3_a0", cap_a[0], 32'h7FFF7FFF);
    program_cfg(0, 4, 1, 2, 2, 0, -32000, 0, 2000, 0);
    run_cfg(0);
    chk("t3_b1", cap_b[1], 32'h80008000);

    // 4: continuous mode, stopped mid-frame
    program_cfg(2, 8, 0, 3, 5, 4, 100, 500, 600, 700);
    run_cfg(19);

    // 5: B window truncated at the frame end
    program_cfg(0, 8, 2, 6, 14, 0, 0, 1000, 1000, 1000);
    run_cfg(0);
    chk("t5_b7", cap_b[7], 32'hFC18FC18);
    chk("t5_b8", cap_b[8], 32'h00000000);
    chk("t5_b15", cap_b[15], 32'hFC18FC18);

    // 6: reset during RUN, then holdoff honoured on re-enable
    program_cfg(3, 10, 0, 4, 3, 3, 50, 300, 300, 300);
    pe.gen_enable = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("t6_data", pe.adc_data_b, 32'd0);
    chk("t6_valid", pe.adc_valid, 32'd0);
    chk("t6_enable", pe.adc_enable, 32'd0);
    chk("t6_fs", pe.frame_start, 32'd0);
    rstn = 1'b1;
    pe.gen_enable = 1'b0;
    program_cfg(3, 10, 1, 4, 3, 3, 50, 300, 300, 300);
    @(posedge clk); #1;
    run_cfg(0);

    // Random configurations
    for (int r = 0; r < 8; r++) begin
      program_cfg($urandom_range(4, 0), $urandom_range(12, 0), $urandom_range(3, 1),
                  $urandom_range(8, 0), $urandom_range(20, 0), $urandom_range(12, 0),
                  $urandom, $urandom, $urandom, $urandom);
      run_cfg(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
